// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw board inputs and the conditioned clk-domain
// outputs. The board/bench side is the master, the conditioner is the slave.
interface input_conditioner_if;
    logic [3:0] btn_raw;
    logic [7:0] sw_raw;
    logic [3:0] btn_lvl;
    logic [3:0] btn_press;
    logic [3:0] btn_rel;
    logic [7:0] sw_out;
    logic       sw_chg;
    logic       tick;

    modport master (
        output btn_raw, sw_raw,
        input  btn_lvl, btn_press, btn_rel, sw_out, sw_chg, tick
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_lvl, btn_press, btn_rel, sw_out, sw_chg, tick
    );
endinterface

// File: rtl/input_conditioner.sv
// Front-end conditioning for the lab board: two-flop synchronisers, per-button
// debounce with press/release pulses, bus-wide switch debounce and a free-running
// tick enable. Every output is a flop; raw inputs only ever reach the s1 stage.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input_conditioner_if.slave    bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TCNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);

    logic [11:0]      s1;
    logic [11:0]      s2;
    logic [3:0]       btn_s2;
    logic [7:0]       sw_s2;

    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       btn_lvl;
    logic [3:0]       btn_press;
    logic [3:0]       btn_rel;

    logic [7:0]       prev_sw;
    logic [7:0]       sw_out;
    logic [CNT_W-1:0] sw_cnt;
    logic             sw_chg;

    logic [TCNT_W-1:0] tcnt;
    logic              tick;

    assign btn_s2 = s2[3:0];
    assign sw_s2  = s2[11:4];

    // Two-stage synchroniser for all twelve raw bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {bus.sw_raw, bus.btn_raw};
            s2 <= s1;
        end
    end

    // Independent debounce per button; any return to the accepted level drops all credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            btn_lvl   <= '0;
            btn_press <= '0;
            btn_rel   <= '0;
        end else begin
            btn_press <= '0;
            btn_rel   <= '0;
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_LAST) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    btn_lvl[i]   <= btn_s2[i];
                    cnt[i]       <= '0;
                    btn_press[i] <= btn_s2[i];
                    btn_rel[i]   <= ~btn_s2[i];
                end
            end
        end
    end

    // Bus-wide switch debounce: a new sampled value restarts the hold, and the
    // cycle that first shows it counts as the first cycle of that hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sw <= '0;
            sw_out  <= '0;
            sw_cnt  <= '0;
            sw_chg  <= 1'b0;
        end else begin
            prev_sw <= sw_s2;
            sw_chg  <= 1'b0;
            if (sw_s2 == sw_out) begin
                sw_cnt <= '0;
            end else if (sw_s2 != prev_sw) begin
                sw_cnt <= CNT_ONE;
            end else if (sw_cnt != CNT_LAST) begin
                sw_cnt <= sw_cnt + 1'b1;
            end else begin
                sw_out <= sw_s2;
                sw_cnt <= '0;
                sw_chg <= 1'b1;
            end
        end
    end

    // Free-running divider; tick is registered one cycle after the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TCNT_LAST);
            tcnt <= (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;
        end
    end

    assign bus.btn_lvl   = btn_lvl;
    assign bus.btn_press = btn_press;
    assign bus.btn_rel   = btn_rel;
    assign bus.sw_out    = sw_out;
    assign bus.sw_chg    = sw_chg;
    assign bus.tick      = tick;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end conditioning stage for the lab board. It sits between the raw pushbuttons/slide switches and the lab control FSM.
- Synchronises and debounces the four direction buttons and eight switches.
- Emits one-cycle press/release pulses.
- Generates the slow tick enable that paces the downstream state machines.
- The downstream block consumes only conditioned, clk-domain signals.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); legal range >= 2
TICK_DIV, 50000000, tick period in clk cycles; legal range >= 2
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
btn_raw  input  4  raw buttons; bit0=btnD, bit1=btnR, bit2=btnU, bit3=btnL; asynchronous to clk
sw_raw  input  8  raw slide switches; asynchronous to clk
btn_lvl  output  4  debounced button level
btn_press  output  4  one-cycle pulse on accepted 0->1 of the matching btn_lvl bit
btn_rel  output  4  one-cycle pulse on accepted 1->0 of the matching btn_lvl bit
sw_out  output  8  debounced switch bus
sw_chg  output  1  one-cycle pulse when sw_out updates
tick  output  1  one-cycle enable every TICK_DIV cycles

Behaviour:
Reset:
- rst is asynchronous, active-high. Clock is clk.
- While rst is high, all sync flops, counters, btn_lvl, btn_press, btn_rel, sw_out, sw_chg and tick are 0.

Synchronisers:
- Two flip-flop stages per raw bit (s1 then s2), for all 12 bits. No combinational use of raw inputs.

Per-button debounce (4 independent instances, counter cnt[i]):
- If s2[i] == btn_lvl[i]: cnt[i] <= 0.
- Else if cnt[i] != DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
- Else (commit): btn_lvl[i] <= s2[i]; cnt[i] <= 0; btn_press[i] or btn_rel[i] is high for exactly that next cycle.
- Any bounce back to btn_lvl[i] before commit clears cnt[i]. No partial credit is kept.
- Latency: btn_lvl changes DEBOUNCE_CYCLES edges after s2 changes, i.e. 2+DEBOUNCE_CYCLES edges after a clean raw change.
- btn_press and btn_rel are mutually exclusive per bit. Multiple bits may pulse in the same cycle.

Switch debounce (one shared counter, bus-wide):
- The tracked value is s2_sw compared with sw_out.
- A mismatch holding the same s2_sw value for DEBOUNCE_CYCLES consecutive cycles commits: sw_out <= s2_sw, sw_chg pulses 1 cycle.
- If s2_sw changes to any new value during the wait, the counter restarts from 0, even if the new value also differs from sw_out.
- Implementation keeps a last-sample register, prev_sw, for this check.

Tick divider:
- tcnt counts 0..TICK_DIV-1 and wraps.
- tick = 1 during the cycle after tcnt == TICK_DIV-1 is registered (registered output).
- The first tick occurs exactly TICK_DIV edges after rst deasserts. After that, period = TICK_DIV.
- Free-running, independent of inputs.

Reset mid-operation:
- All in-progress debounce counts are discarded and any pulse is cancelled immediately.
- An input held through reset release is accepted as a fresh event: btn_press fires 2+DEBOUNCE_CYCLES edges later.

Output timing:
- All outputs are registered. No output depends combinationally on any input.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, TICK_DIV=10.)
1. Clean press: rst released, btn_raw=4'b0001 held -> btn_press[0]=1 for one cycle at edge 6 after the input change, btn_lvl=4'b0001 from then on. Release -> btn_rel[0] pulse 6 edges later, btn_lvl=0.
2. Bounce rejection: btn_raw[2] toggles 1,0,1,0 with each level held 3 cycles, then held at 1 -> no pulses during toggling. Exactly one btn_press[2] 6 edges after the final rising change.
3. Simultaneous: btn_raw 0000->1010 in one cycle -> btn_press=4'b1010 in the same single cycle, btn_lvl=4'b1010.
4. Switch bus: sw_raw 00->A5 held -> sw_out=8'hA5 with a single sw_chg pulse 6 edges later. Changing to 5A after 2 cycles of A5 -> sw_out stays 00 until 5A has been stable 4 cycles, then sw_out=8'h5A with one sw_chg.
5. Tick: after rst release, tick pulses at edges 10, 20, 30, each exactly 1 cycle wide, with no dependence on buttons.
6. Reset mid-debounce: btn_raw[1]=1 for 3 cycles, assert rst for 2 cycles, keep btn_raw[1]=1 -> no pulse during or immediately after reset. btn_press[1] fires 6 edges after rst deasserts, and tick restarts from count 0.
